dds_sin_ctrl: RTL and testbench

- Sequences the 2048x8 sine ROM (11-bit address, 8-bit data, synchronous read, no output register) as a DDS source for the DA path.
- Holds a phase accumulator, applies a phase offset and an amplitude scale, and issues ROM addresses every cycle while running.
- Emits a scaled offset-binary sample stream with a valid flag.
- Takes configuration through a valid/ready handshake and run control through start/stop pulses.

---
 rtl/dds_pkg.sv | 25 ++
 rtl/dds_amp_scale.sv | 65 ++++++
 rtl/dds_sin_ctrl.sv | 146 ++++++++++++++
 tb/tb_dds_sin_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dds_pkg.sv
// ---------------------------------------------------------------------------
// dds_pkg
// Shared definitions for the DDS sine controller:
//   state_t   - controller FSM states (IDLE / RUN / DRAIN)
//   AMP_FULL  - full-scale amplitude code (unity gain)
//   AMP_SHIFT - right shift applied after the amplitude multiply
//   midscale  - offset-binary zero for a given sample width
// ---------------------------------------------------------------------------
package dds_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int unsigned AMP_FULL  = 16;
  localparam int unsigned AMP_SHIFT = 4;

  // Offset-binary zero: 2^(data_w-1).
  function automatic int unsigned midscale(input int unsigned data_w);
    return 32'd1 << (data_w - 32'd1);
  endfunction

endpackage

// File: rtl/dds_amp_scale.sv
// ---------------------------------------------------------------------------
// dds_amp_scale
// Registered amplitude scaler for offset-binary samples.
//   wave = ((rom - mid) * amp) >>> AMP_SHIFT + mid, with a valid passthrough.
// Ports:
//   clk, rst_n      - clock, asynchronous active-low reset
//   clr_i           - force output to midscale and drop valid
//   in_valid_i      - rom_data_i carries a sample this cycle
//   rom_data_i      - offset-binary ROM sample
//   amp_i           - amplitude 0..AMP_FULL (already saturated upstream)
//   wave_data_o     - registered scaled sample
//   wave_valid_o    - wave_data_o is a new sample this cycle
// ---------------------------------------------------------------------------
import dds_pkg::*;

module dds_amp_scale #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] rom_data_i,
  input  logic [4:0]        amp_i,
  output logic [DATA_W-1:0] wave_data_o,
  output logic              wave_valid_o
);

  localparam int unsigned MID = midscale(DATA_W);
  // Product width: signed sample (DATA_W+1) times signed amp (6) bits.
  localparam int unsigned P_W = DATA_W + 7;

  logic signed [DATA_W:0] s_d;
  logic signed [P_W-1:0]  p_d;
  logic [DATA_W-1:0]      wave_d;
  logic [DATA_W-1:0]      wave_data_q;
  logic                   wave_valid_q;

  always_comb begin
    s_d    = $signed({1'b0, rom_data_i}) - $signed((DATA_W + 1)'(MID));
    p_d    = P_W'(s_d) * P_W'($signed({1'b0, amp_i}));
    // Arithmetic shift floors toward minus infinity; with amp <= AMP_FULL the
    // result always lands back inside the DATA_W range, so truncation is safe.
    wave_d = DATA_W'((p_d >>> AMP_SHIFT) + $signed(P_W'(MID)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wave_data_q  <= DATA_W'(MID);
      wave_valid_q <= 1'b0;
    end else if (clr_i) begin
      wave_data_q  <= DATA_W'(MID);
      wave_valid_q <= 1'b0;
    end else if (in_valid_i) begin
      wave_data_q  <= wave_d;
      wave_valid_q <= 1'b1;
    end else begin
      wave_valid_q <= 1'b0;
    end
  end

  assign wave_data_o  = wave_data_q;
  assign wave_valid_o = wave_valid_q;

endmodule

// File: rtl/dds_sin_ctrl.sv
// ---------------------------------------------------------------------------
// dds_sin_ctrl
// DDS sequencer for an external synchronous-read sine ROM. Holds a phase
// accumulator, adds a phase offset to form ROM addresses, scales the returned
// samples by an amplitude and emits an offset-binary stream with valid.
// Ports:
//   clk, rst_n                   - clock, asynchronous active-low reset
//   cfg_valid / cfg_ready        - configuration handshake
//   cfg_freq, cfg_phase, cfg_amp - tuning word, address offset, amplitude
//   start, stop                  - run control pulses
//   rom_addr / rom_data          - ROM address (registered) and read data
//   wave_data / wave_valid       - scaled sample stream
//   busy                         - high in RUN or DRAIN
// ---------------------------------------------------------------------------
import dds_pkg::*;

module dds_sin_ctrl #(
  parameter int unsigned PHASE_W = 32,
  parameter int unsigned ADDR_W  = 11,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ROM_LAT = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [PHASE_W-1:0] cfg_freq,
  input  logic [ADDR_W-1:0]  cfg_phase,
  input  logic [4:0]         cfg_amp,
  input  logic               start,
  input  logic               stop,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [DATA_W-1:0]  rom_data,
  output logic [DATA_W-1:0]  wave_data,
  output logic               wave_valid,
  output logic               busy
);

  localparam int unsigned CNT_W = (ROM_LAT < 1) ? 1 : $clog2(ROM_LAT + 1);

  state_t             state_q;
  logic [PHASE_W-1:0] acc_q;
  logic [PHASE_W-1:0] freq_q;
  logic [ADDR_W-1:0]  phase_q;
  logic [4:0]         amp_q;
  logic [ADDR_W-1:0]  rom_addr_q;
  logic [ROM_LAT:0]   vld_pipe_q;   // bit i: address issued i edges ago
  logic [CNT_W-1:0]   drain_cnt_q;
  logic               busy_q;
  logic               cfg_ready_q;

  logic               cfg_fire;
  logic [4:0]         amp_sat;
  logic               issue;
  logic               drain_done;
  logic [PHASE_W-1:0] acc_d;
  logic [ADDR_W-1:0]  addr_d;

  always_comb begin
    cfg_fire   = cfg_valid && cfg_ready_q;
    amp_sat    = (cfg_amp > 5'(AMP_FULL)) ? 5'(AMP_FULL) : cfg_amp;
    // A stop on a RUN cycle suppresses that cycle's address, so only
    // addresses already in flight are flushed during DRAIN.
    issue      = (state_q == RUN) && !stop;
    drain_done = (state_q == DRAIN) && (drain_cnt_q == CNT_W'(ROM_LAT));
    acc_d      = acc_q + freq_q;
    addr_d     = acc_q[PHASE_W-1 -: ADDR_W] + phase_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      freq_q      <= '0;
      phase_q     <= '0;
      amp_q       <= 5'(AMP_FULL);
      rom_addr_q  <= '0;
      vld_pipe_q  <= '0;
      drain_cnt_q <= '0;
      busy_q      <= 1'b0;
      cfg_ready_q <= 1'b1;
    end else begin
      // Retuning in RUN leaves acc untouched, so phase stays continuous.
      if (cfg_fire) begin
        freq_q  <= cfg_freq;
        phase_q <= cfg_phase;
        amp_q   <= amp_sat;
      end

      vld_pipe_q <= {vld_pipe_q[ROM_LAT-1:0], issue};

      case (state_q)
        IDLE: begin
          // stop wins over a simultaneous start.
          if (start && !stop) begin
            state_q <= RUN;
            acc_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          if (stop) begin
            state_q     <= DRAIN;
            drain_cnt_q <= '0;
            cfg_ready_q <= 1'b0;
          end else begin
            acc_q      <= acc_d;
            rom_addr_q <= addr_d;
          end
        end
        DRAIN: begin
          if (drain_done) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            cfg_ready_q <= 1'b1;
          end else begin
            drain_cnt_q <= drain_cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q     <= IDLE;
          busy_q      <= 1'b0;
          cfg_ready_q <= 1'b1;
        end
      endcase
    end
  end

  dds_amp_scale #(
    .DATA_W(DATA_W)
  ) u_scale (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_i       (drain_done),
    .in_valid_i  (vld_pipe_q[ROM_LAT]),
    .rom_data_i  (rom_data),
    .amp_i       (amp_q),
    .wave_data_o (wave_data),
    .wave_valid_o(wave_valid)
  );

  assign rom_addr  = rom_addr_q;
  assign busy      = busy_q;
  assign cfg_ready = cfg_ready_q;

endmodule

// File: tb/tb_dds_sin_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dds_sin_ctrl
// Directed bench for dds_sin_ctrl with a behavioural 2048x8 synchronous ROM.
// ROM contents: addr[7:0] ^ addr[10:8], except 512 -> 0xFF and 513 -> 0x00.
// ---------------------------------------------------------------------------
module tb_dds_sin_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [31:0] cfg_freq;
  logic [10:0] cfg_phase;
  logic [4:0]  cfg_amp;
  logic        start;
  logic        stop;
  logic [10:0] rom_addr;
  logic [7:0]  rom_data = 8'h00;
  logic [7:0]  wave_data;
  logic        wave_valid;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dds_sin_ctrl #(
    .PHASE_W(32),
    .ADDR_W (11),
    .DATA_W (8),
    .ROM_LAT(1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_freq  (cfg_freq),
    .cfg_phase (cfg_phase),
    .cfg_amp   (cfg_amp),
    .start     (start),
    .stop      (stop),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .wave_data (wave_data),
    .wave_valid(wave_valid),
    .busy      (busy)
  );

  function automatic logic [7:0] rom_val(input logic [10:0] a);
    if (a == 11'd512) return 8'hFF;
    if (a == 11'd513) return 8'h00;
    return a[7:0] ^ {5'b0, a[10:8]};
  endfunction

  always @(posedge clk) rom_data <= rom_val(rom_addr);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Inputs change just after the falling edge; outputs sampled there too.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic cfg_start(input logic [31:0] f, input logic [10:0] ph, input logic [4:0] a);
    cfg_valid = 1'b1;
    cfg_freq  = f;
    cfg_phase = ph;
    cfg_amp   = a;
    start     = 1'b1;
    step();
    cfg_valid = 1'b0;
    start     = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
    step();
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    rst_n     = 1'b0;
    cfg_valid = 1'b0;
    cfg_freq  = '0;
    cfg_phase = '0;
    cfg_amp   = '0;
    start     = 1'b0;
    stop      = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // Reset / idle
    chk("rst_addr",   32'(rom_addr),   32'h0);
    chk("rst_wave",   32'(wave_data),  32'h80);
    chk("rst_valid",  32'(wave_valid), 32'h0);
    chk("rst_busy",   32'(busy),       32'h0);
    chk("rst_ready",  32'(cfg_ready),  32'h1);

    // Unit step, amp=16 passthrough
    cfg_start(32'h0020_0000, 11'd0, 5'd16);
    chk("us_busy",    32'(busy),       32'h1);
    chk("us_v0",      32'(wave_valid), 32'h0);
    step();
    chk("us_addr0",   32'(rom_addr),   32'd0);
    chk("us_v1",      32'(wave_valid), 32'h0);
    step();
    chk("us_addr1",   32'(rom_addr),   32'd1);
    chk("us_v2",      32'(wave_valid), 32'h0);
    step();
    chk("us_addr2",   32'(rom_addr),   32'd2);
    chk("us_v3",      32'(wave_valid), 32'h1);
    chk("us_wave0",   32'(wave_data),  32'h00);
    for (int i = 1; i <= 5; i++) begin
      step();
      chk("us_addr",  32'(rom_addr),   32'(i + 2));
      chk("us_wave",  32'(wave_data),  32'(i));
    end

    // Address wrap 2047 -> 0
    found = 1'b0;
    for (int i = 0; i < 2100 && !found; i++) begin
      step();
      if (rom_addr == 11'd2047) found = 1'b1;
    end
    chk("wrap_found", 32'(found),      32'h1);
    chk("wrap_w2045", 32'(wave_data),  32'hFA);
    step();
    chk("wrap_addr0", 32'(rom_addr),   32'd0);
    chk("wrap_w2046", 32'(wave_data),  32'hF9);
    step();
    chk("wrap_addr1", 32'(rom_addr),   32'd1);
    chk("wrap_w2047", 32'(wave_data),  32'hF8);
    step();
    chk("wrap_addr2", 32'(rom_addr),   32'd2);
    chk("wrap_w0",    32'(wave_data),  32'h00);

    // Stop and drain; start/cfg during DRAIN ignored
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("dr_busy0",   32'(busy),       32'h1);
    chk("dr_ready0",  32'(cfg_ready),  32'h0);
    start     = 1'b1;
    cfg_valid = 1'b1;
    cfg_freq  = 32'h0080_0000;
    cfg_phase = 11'd7;
    cfg_amp   = 5'd16;
    step();
    start     = 1'b0;
    cfg_valid = 1'b0;
    chk("dr_busy1",   32'(busy),       32'h1);
    chk("dr_ready1",  32'(cfg_ready),  32'h0);
    chk("dr_lastv",   32'(wave_valid), 32'h1);
    chk("dr_lastw",   32'(wave_data),  32'h02);
    step();
    chk("dr_idle",    32'(busy),       32'h0);
    chk("dr_ready2",  32'(cfg_ready),  32'h1);
    chk("dr_novalid", 32'(wave_valid), 32'h0);
    chk("dr_mid",     32'(wave_data),  32'h80);
    step();
    chk("dr_nostart", 32'(busy),       32'h0);
    chk("dr_novalid2",32'(wave_valid), 32'h0);
    // Old config must still be in force
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("dr_oldcfg0", 32'(rom_addr),   32'd0);
    step();
    chk("dr_oldcfg1", 32'(rom_addr),   32'd1);
    do_stop();

    // Phase offset 512, half amplitude, cfg coincident with start
    cfg_start(32'h0020_0000, 11'd512, 5'd8);
    step();
    chk("ph_addr512", 32'(rom_addr),   32'd512);
    step();
    chk("ph_addr513", 32'(rom_addr),   32'd513);
    step();
    chk("ph_valid",   32'(wave_valid), 32'h1);
    chk("ph_wFF",     32'(wave_data),  32'hBF);
    step();
    chk("ph_w00",     32'(wave_data),  32'h40);
    do_stop();

    // amp=20 saturates; phase-continuous retune at address 100
    cfg_start(32'h0020_0000, 11'd0, 5'd20);
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      if (rom_addr == 11'd99) found = 1'b1;
      else step();
    end
    chk("rt_found",   32'(found),      32'h1);
    chk("sat_wave",   32'(wave_data),  32'd97);
    cfg_valid = 1'b1;
    cfg_freq  = 32'h0040_0000;
    cfg_phase = 11'd0;
    cfg_amp   = 5'd20;
    step();
    cfg_valid = 1'b0;
    chk("rt_a100",    32'(rom_addr),   32'd100);
    step();
    chk("rt_a101",    32'(rom_addr),   32'd101);
    step();
    chk("rt_a103",    32'(rom_addr),   32'd103);
    step();
    chk("rt_a105",    32'(rom_addr),   32'd105);
    do_stop();

    // freq=0: constant address = phase, valid every cycle
    cfg_start(32'h0, 11'h300, 5'd16);
    step();
    chk("f0_addr_a",  32'(rom_addr),   32'h300);
    step();
    step();
    chk("f0_addr_b",  32'(rom_addr),   32'h300);
    chk("f0_valid_a", 32'(wave_valid), 32'h1);
    chk("f0_wave_a",  32'(wave_data),  32'h03);
    step();
    chk("f0_valid_b", 32'(wave_valid), 32'h1);
    chk("f0_wave_b",  32'(wave_data),  32'h03);
    do_stop();

    // start and stop together in IDLE: stop wins
    start = 1'b1;
    stop  = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b0;
    chk("ss_busy",    32'(busy),       32'h0);
    step();
    step();
    chk("ss_addr",    32'(rom_addr),   32'h300);
    chk("ss_valid",   32'(wave_valid), 32'h0);

    // Asynchronous reset mid-RUN
    cfg_start(32'h0020_0000, 11'd5, 5'd16);
    repeat (4) step();
    chk("ar_running", 32'(wave_valid), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid",   32'(wave_valid), 32'h0);
    chk("ar_addr",    32'(rom_addr),   32'h0);
    chk("ar_wave",    32'(wave_data),  32'h80);
    chk("ar_busy",    32'(busy),       32'h0);
    chk("ar_ready",   32'(cfg_ready),  32'h1);
    step();
    rst_n = 1'b1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
